// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a small helper used for the terminal-count decode.
package univ_shift_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

    // Terminal count is a pure function of the mode and the all-ones /
    // all-zeros flags, so cascaded stages can share the same decode.
    function automatic logic tc_decode(input logic [MODE_W-1:0] mode,
                                       input logic              all_ones,
                                       input logic              all_zeros);
        return ((mode == MODE_INC) && all_ones) ||
               ((mode == MODE_DEC) && all_zeros);
    endfunction

endpackage

// File: rtl/univ_shift_reg_dff_sre.sv
// Single-bit storage element: synchronous active-high reset to a per-bit
// value, clock enable, and true/complement outputs.
module dff_sre #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qn
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    // Complement is derived from the same flop so q and qn can never agree.
    assign q  = q_reg;
    assign qn = ~q_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, shift, rotate and up/down count,
// built from one dff_sre per bit with the next-state mux kept here.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              C,
    input  logic              R,
    input  logic              EN,
    input  logic [2:0]        M,
    input  logic [WIDTH-1:0]  D,
    input  logic              SL,
    input  logic              SR,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qn,
    output logic              TC
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qn_reg;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        case (M)
            MODE_HOLD: q_next = q_reg;
            MODE_LOAD: q_next = D;
            MODE_SHL:  q_next = {q_reg[WIDTH-2:0], SL};
            MODE_SHR:  q_next = {SR, q_reg[WIDTH-1:1]};
            MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            MODE_ROR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
            MODE_INC:  q_next = q_reg + WIDTH'(1);
            MODE_DEC:  q_next = q_reg - WIDTH'(1);
            default:   q_next = q_reg;
        endcase
    end

    // Reset priority and the EN=0 hold are handled inside each bit flop.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_sre #(
                .RST_VAL (RESET_VAL[gi])
            ) u_bit (
                .clk  (C),
                .srst (R),
                .en   (EN),
                .d    (q_next[gi]),
                .q    (q_reg[gi]),
                .qn   (qn_reg[gi])
            );
        end
    endgenerate

    assign Q  = q_reg;
    assign Qn = qn_reg;
    assign TC = tc_decode(M, &q_reg, ~|q_reg);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed
// scenarios plus a randomized run against an arithmetic reference model.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         r;
    logic         en;
    logic [2:0]   m;
    logic [W-1:0] d;
    logic         sl;
    logic         sr;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         tc;

    int n_tests = 0;
    int n_fail  = 0;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .C  (clk),
        .R  (r),
        .EN (en),
        .M  (m),
        .D  (d),
        .SL (sl),
        .SR (sr),
        .Q  (q),
        .Qn (qn),
        .TC (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [W-1:0] val);
        r  = 1'b0;
        en = 1'b1;
        m  = MODE_LOAD;
        d  = val;
        step();
    endtask

    // Reference: next value computed with plain integer arithmetic mod 256.
    function automatic int ref_next(input int cur, input logic [2:0] mode,
                                    input int din, input int s_l, input int s_r);
        int res;
        res = cur;
        if (mode == MODE_LOAD) res = din;
        else if (mode == MODE_SHL) res = (cur * 2 + s_l) % 256;
        else if (mode == MODE_SHR) res = cur / 2 + s_r * 128;
        else if (mode == MODE_ROL) res = (cur * 2) % 256 + cur / 128;
        else if (mode == MODE_ROR) res = cur / 2 + (cur % 2) * 128;
        else if (mode == MODE_INC) res = (cur + 1) % 256;
        else if (mode == MODE_DEC) res = (cur + 255) % 256;
        return res;
    endfunction

    task automatic test_reset();
        r  = 1'b1;
        en = 1'b1;
        m  = MODE_INC;
        d  = 8'hFF;
        sl = 1'b1;
        sr = 1'b1;
        step();
        n_tests++;
        if (q !== 8'h00) begin
            $display("FAIL reset_q got %h want %h", q, 8'h00);
            n_fail++;
        end
        n_tests++;
        if (qn !== 8'hFF) begin
            $display("FAIL reset_qn got %h want %h", qn, 8'hFF);
            n_fail++;
        end
        $display("[TB] reset: q=%h qn=%h", q, qn);
    endtask

    task automatic test_load();
        r  = 1'b0;
        en = 1'b1;
        m  = MODE_HOLD;
        d  = 8'h11;
        #2;
        m  = MODE_LOAD;
        d  = 8'hA5;
        step();
        n_tests++;
        if (q !== 8'hA5) begin
            $display("FAIL load_q got %h want %h", q, 8'hA5);
            n_fail++;
        end
        n_tests++;
        if (qn !== 8'h5A) begin
            $display("FAIL load_qn got %h want %h", qn, 8'h5A);
            n_fail++;
        end
        $display("[TB] load: q=%h qn=%h", q, qn);
    endtask

    task automatic test_shift_rotate();
        load_value(8'h81);
        m = MODE_SHL; sl = 1'b1; sr = 1'b1; d = 8'h00;
        step();
        n_tests++;
        if (q !== 8'h03) begin
            $display("FAIL shl got %h want %h", q, 8'h03);
            n_fail++;
        end
        $display("[TB] shl: q=%h", q);
        m = MODE_SHR; sr = 1'b0; sl = 1'b1;
        step();
        n_tests++;
        if (q !== 8'h01) begin
            $display("FAIL shr got %h want %h", q, 8'h01);
            n_fail++;
        end
        $display("[TB] shr: q=%h", q);
        load_value(8'h81);
        m = MODE_ROL; sl = 1'b0; sr = 1'b1; d = 8'hFF;
        step();
        n_tests++;
        if (q !== 8'h03) begin
            $display("FAIL rol got %h want %h", q, 8'h03);
            n_fail++;
        end
        $display("[TB] rol: q=%h", q);
        load_value(8'h81);
        m = MODE_ROR; sl = 1'b1; sr = 1'b0; d = 8'h00;
        step();
        n_tests++;
        if (q !== 8'hC0) begin
            $display("FAIL ror got %h want %h", q, 8'hC0);
            n_fail++;
        end
        $display("[TB] ror: q=%h", q);
    endtask

    task automatic test_count();
        logic [W-1:0] exp_q [5];
        logic         exp_tc [5];
        exp_q  = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF};
        exp_tc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        load_value(8'hFE);
        for (int i = 0; i < 5; i++) begin
            m = (i < 3) ? MODE_INC : MODE_DEC;
            d = 8'($urandom);
            step();
            n_tests++;
            if (q !== exp_q[i] || tc !== exp_tc[i]) begin
                $display("FAIL count[%0d] got q=%h tc=%b want q=%h tc=%b",
                         i, q, tc, exp_q[i], exp_tc[i]);
                n_fail++;
            end
            $display("[TB] count[%0d]: m=%b q=%h tc=%b", i, m, q, tc);
        end
    endtask

    task automatic test_hold();
        load_value(8'h3C);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m  = 3'(i);
            d  = 8'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            step();
            n_tests++;
            if (q !== 8'h3C || tc !== 1'b0) begin
                $display("FAIL hold[%0d] got q=%h tc=%b want q=%h tc=0", i, q, tc, 8'h3C);
                n_fail++;
            end
            $display("[TB] hold[%0d]: m=%b q=%h tc=%b", i, m, q, tc);
        end
        // TC must still reflect M and Q while disabled.
        load_value(8'hFF);
        en = 1'b0;
        m  = MODE_INC;
        #1;
        n_tests++;
        if (tc !== 1'b1) begin
            $display("FAIL hold_tc got %b want 1", tc);
            n_fail++;
        end
        $display("[TB] hold_tc: q=%h tc=%b", q, tc);
    endtask

    task automatic test_reset_midcount();
        logic [W-1:0] exp_q [4];
        exp_q = '{8'h11, 8'h12, 8'h00, 8'h01};
        load_value(8'h10);
        m = MODE_INC;
        for (int i = 0; i < 4; i++) begin
            r = (i == 2);
            step();
            n_tests++;
            if (q !== exp_q[i] || qn !== ~exp_q[i]) begin
                $display("FAIL midreset[%0d] got q=%h qn=%h want q=%h", i, q, qn, exp_q[i]);
                n_fail++;
            end
            $display("[TB] midreset[%0d]: r=%b q=%h", i, r, q);
        end
        r = 1'b0;
    endtask

    task automatic test_random();
        int           model_q;
        logic [W-1:0] exp;
        logic         exp_tc;
        int           errs;
        errs = 0;
        r = 1'b1;
        step();
        model_q = 0;
        r = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            en = ($urandom_range(0, 7) != 0);
            m  = 3'($urandom);
            d  = 8'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            if (r) model_q = 0;
            else if (en) model_q = ref_next(model_q, m, int'(d), int'(sl), int'(sr));
            step();
            exp    = 8'(model_q);
            exp_tc = (m == MODE_INC && model_q == 255) || (m == MODE_DEC && model_q == 0);
            n_tests++;
            if (q !== exp || qn !== ~exp || tc !== exp_tc) begin
                $display("FAIL random[%0d] got q=%h qn=%h tc=%b want q=%h qn=%h tc=%b",
                         i, q, qn, tc, exp, ~exp, exp_tc);
                n_fail++;
                errs++;
            end
        end
        r = 1'b0;
        $display("[TB] random: 1000 edges, %0d errors", errs);
    endtask

    initial begin
        r  = 1'b0;
        en = 1'b0;
        m  = MODE_HOLD;
        d  = '0;
        sl = 1'b0;
        sr = 1'b0;
        test_reset();
        test_load();
        test_shift_rotate();
        test_count();
        test_hold();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value loaded on reset.
REQ-003 Port C  input  1  clock; all state changes on the rising edge; the block SHALL use only this clock.
REQ-004 Port R  input  1  reset; synchronous, active-high.
REQ-005 Port EN  input  1  enable; 0 means hold.
REQ-006 Port M  input  3  mode select (encodings per REQ-014).
REQ-007 Port D  input  WIDTH  parallel load data.
REQ-008 Port SL  input  1  serial input for shift-left (enters bit 0).
REQ-009 Port SR  input  1  serial input for shift-right (enters bit WIDTH-1).
REQ-010 Port Q  output  WIDTH  registered state.
REQ-011 Port Qn  output  WIDTH  bitwise complement of Q at all times.
REQ-012 Port TC  output  1  terminal count: 1 when M=110 and Q is all-ones, or when M=111 and Q is all-zeros; else 0 (combinational from M and Q).

Function
REQ-013 Priority at each rising edge of C SHALL be: R, then EN=0 (hold), then mode M.
REQ-014 Mode encodings SHALL be:
- 000 hold
- 001 load D
- 010 shift left, Q <= {Q[W-2:0], SL}
- 011 shift right, Q <= {SR, Q[W-1:1]}
- 100 rotate left
- 101 rotate right
- 110 count up
- 111 count down
REQ-015 Latency SHALL be exactly one clock: the Q update is visible after the edge that samples R/EN/M/D/SL/SR.
REQ-016 Count up SHALL wrap from all-ones to 0; count down SHALL wrap from 0 to all-ones; arithmetic is modulo 2^WIDTH with no saturation.
REQ-017 Rotate modes SHALL ignore SL and SR; shift modes SHALL ignore D; hold and count modes SHALL ignore D, SL and SR.
REQ-018 M and D changing between edges SHALL have no effect on Q until the next rising edge.
REQ-019 TC SHALL remain valid when EN=0, so that an external cascade can gate the next stage.
REQ-020 Qn SHALL never equal Q in any bit, including during and immediately after reset.

Reset
REQ-021 While R=1 at a rising edge, Q SHALL become RESET_VAL and Qn SHALL become ~RESET_VAL, regardless of EN, M, D, SL and SR.
REQ-022 Reset asserted mid-operation (while shifting or counting) SHALL abort that operation at the same edge; there is no pending state.
REQ-023 Before the first reset edge Q is undefined; benches SHALL apply R for at least one edge.
REQ-024 After R deasserts, the first edge with R=0 SHALL perform the normal mode operation.

Structure
REQ-025 Mode encodings SHALL be localparams in shared package univ_shift_reg_pkg.
- MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC
- Benches SHALL use the same package.
REQ-026 The storage SHALL be WIDTH instances of sub-module dff_sre (single D flip-flop: sync active-high reset to a per-bit value, enable, Q and Qn outputs).
REQ-027 The next-state multiplexer SHALL live in univ_shift_reg and be fully combinational, with a default branch equal to hold.

Verification (WIDTH=8, RESET_VAL=0)
REQ-028 R=1 for 1 edge, then EN=1 M=001 D=8'hA5 -> Q=8'hA5, Qn=8'h5A after one edge.
REQ-029 Q=8'h81, M=010 SL=1 -> 8'h03; then M=011 SR=0 -> 8'h01; then M=100 from 8'h81 -> 8'h03; then M=101 from 8'h81 -> 8'hC0.
REQ-030 Q=8'hFE, M=110, 3 edges -> 8'hFF (TC=1), 8'h00 (TC=0), 8'h01; from 8'h01, M=111, 2 edges -> 8'h00 (TC=1), 8'hFF.
REQ-031 Q=8'h3C, EN=0, M cycled through all eight codes over 8 edges -> Q stays 8'h3C; TC=0 throughout.
REQ-032 Counting up from 8'h10, R=1 on the third edge -> Q=8'h12 then 8'h00; with R=0, M=110 on the next edge -> 8'h01.
REQ-033 Random M/D/SL/SR for 1000 edges compared against a reference model -> zero mismatches, and Qn==~Q checked at every edge.
